// File: rtl/adder_result_checker.sv
// adder_result_checker: golden-sum scoreboard aligned to an adder's latency,
// with saturating pass/fail counters and first-mismatch capture.
module adder_result_checker #(
  parameter int width       = 32,
  parameter int LATENCY     = 1,
  parameter int NUM_VECTORS = 10,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             IN_VALID,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             C_IN,
  input  logic [width:0]   DUT_Q,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] PASS_CNT,
  output logic [CNT_W-1:0] FAIL_CNT,
  output logic             FAIL_FLAG,
  output logic [width:0]   FIRST_EXP,
  output logic [width:0]   FIRST_GOT
);
  localparam int L    = LATENCY > 0 ? LATENCY : 1;
  localparam int PW   = L * (width + 1);
  localparam int VC_W = $clog2(NUM_VECTORS + 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [VC_W-1:0]       r_vcnt;
  logic [L:1]            r_vld;
  logic [L:1][width:0]   r_exp;
  logic [CNT_W-1:0]      r_pass, r_fail;
  logic                  r_flag;
  logic [width:0]        r_fexp, r_fgot;
  logic                  w_acc, w_start, w_last, w_cmp_v, w_miss;
  logic [width:0]        w_exp, w_cmp_exp;
  assign w_acc     = r_state == S_RUN && IN_VALID;
  assign w_start   = START && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last    = w_acc && r_vcnt == VC_W'(NUM_VECTORS - 1);
  assign w_exp     = {1'b0, A} + {1'b0, B} + {{width{1'b0}}, C_IN};
  // LATENCY=0 compares straight from the operands; otherwise from the last delay stage
  assign w_cmp_v   = LATENCY == 0 ? w_acc : r_vld[L];
  assign w_cmp_exp = LATENCY == 0 ? w_exp : r_exp[L];
  assign w_miss    = w_cmp_v && w_cmp_exp != DUT_Q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = START ? S_RUN : r_state;
      S_RUN:          w_next = w_last ? (LATENCY == 0 ? S_DONE : S_DRAIN) : S_RUN;
      S_DRAIN:        w_next = |r_vld ? S_DRAIN : S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end
  always_comb begin
    BUSY = r_state == S_RUN || r_state == S_DRAIN;
    DONE = r_state == S_DONE;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_vld <= '0;
    else r_vld <= L'({r_vld, w_acc});
  always_ff @(posedge CLK)
    r_exp <= PW'({r_exp, w_exp});
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_vcnt <= '0;
      r_pass <= '0;
      r_fail <= '0;
      r_flag <= 1'b0;
      r_fexp <= '0;
      r_fgot <= '0;
    end else if (w_start) begin
      r_vcnt <= '0;
      r_pass <= '0;
      r_fail <= '0;
      r_flag <= 1'b0;
      r_fexp <= '0;
      r_fgot <= '0;
    end else begin
      if (w_acc) r_vcnt <= r_vcnt + 1'b1;
      if (w_cmp_v && !w_miss && r_pass != '1) r_pass <= r_pass + 1'b1;
      if (w_miss && r_fail != '1) r_fail <= r_fail + 1'b1;
      if (w_miss) r_flag <= 1'b1;
      if (w_miss && !r_flag) begin
        r_fexp <= w_cmp_exp;
        r_fgot <= DUT_Q;
      end
    end
  assign PASS_CNT  = r_pass;
  assign FAIL_CNT  = r_fail;
  assign FAIL_FLAG = r_flag;
  assign FIRST_EXP = r_fexp;
  assign FIRST_GOT = r_fgot;
endmodule

// File: tb/tb_adder_result_checker.sv
// tb_adder_result_checker: directed runs against a registered-adder instance (transaction model
// checked every cycle) and a combinational, 2-bit-counter instance (literal expectations).
module tb_adder_result_checker;
  logic clk = 0, rst = 0;
  logic st0 = 0, iv0 = 0, bad0 = 0, st1 = 0, iv1 = 0, bad1 = 0, ci = 0;
  logic [31:0] a = 0, b = 0;
  logic [32:0] q0 = 0, q1, sum;
  logic busy0, done0, flag0, busy1, done1, flag1;
  logic [15:0] pass0, fail0;
  logic [1:0] pass1, fail1;
  logic [32:0] fexp0, fgot0, fexp1, fgot1;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign sum = {1'b0, a} + {1'b0, b} + {32'b0, ci};
  always @(posedge clk) q0 <= bad0 ? '0 : sum;
  assign q1 = bad1 ? '0 : sum;

  adder_result_checker #(.width(32), .LATENCY(1), .NUM_VECTORS(10), .CNT_W(16)) u0 (
    .CLK(clk), .RST(rst), .START(st0), .IN_VALID(iv0), .A(a), .B(b), .C_IN(ci), .DUT_Q(q0),
    .BUSY(busy0), .DONE(done0), .PASS_CNT(pass0), .FAIL_CNT(fail0), .FAIL_FLAG(flag0),
    .FIRST_EXP(fexp0), .FIRST_GOT(fgot0));
  adder_result_checker #(.width(32), .LATENCY(0), .NUM_VECTORS(6), .CNT_W(2)) u1 (
    .CLK(clk), .RST(rst), .START(st1), .IN_VALID(iv1), .A(a), .B(b), .C_IN(ci), .DUT_Q(q1),
    .BUSY(busy1), .DONE(done1), .PASS_CNT(pass1), .FAIL_CNT(fail1), .FAIL_FLAG(flag1),
    .FIRST_EXP(fexp1), .FIRST_GOT(fgot1));

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Transaction-level model of u0: one pending compare per cycle, run ends two edges after the 10th vector
  logic m_busy, m_done, m_flag, m_pv;
  logic [15:0] m_pass, m_fail;
  logic [32:0] m_fexp, m_fgot, m_pe, m_pg;
  int m_n, m_left;
  task automatic model_step(input logic r);
    if (r) begin
      m_busy = 0; m_done = 0; m_flag = 0; m_pv = 0; m_pass = 0; m_fail = 0;
      m_fexp = 0; m_fgot = 0; m_n = 0; m_left = 0;
      return;
    end
    if (m_pv) begin
      if (m_pe == m_pg) begin
        if (m_pass != 16'hFFFF) m_pass++;
      end else begin
        if (m_fail != 16'hFFFF) m_fail++;
        if (!m_flag) begin m_fexp = m_pe; m_fgot = m_pg; end
        m_flag = 1;
      end
    end
    m_pv = 0;
    if (!m_busy && st0) begin
      m_busy = 1; m_done = 0; m_flag = 0; m_pass = 0; m_fail = 0;
      m_fexp = 0; m_fgot = 0; m_n = 0;
    end else if (m_busy && m_n < 10 && iv0) begin
      m_pv = 1; m_pe = sum; m_pg = bad0 ? 33'd0 : sum; m_n++;
      if (m_n == 10) m_left = 2;
    end else if (m_busy && m_n == 10) begin
      m_left--;
      if (m_left == 0) begin m_busy = 0; m_done = 1; end
    end
  endtask
  always @(posedge clk or posedge rst) model_step(rst);

  always @(negedge clk)
    chk("model0", {busy0, done0, flag0, pass0, fail0, fexp0, fgot0},
        {m_busy, m_done, m_flag, m_pass, m_fail, m_fexp, m_fgot});

  task automatic vec0(input logic [5:0] x, input logic [5:0] y, input logic c, input logic bad);
    a = {26'b0, x}; b = {26'b0, y}; ci = c; bad0 = bad; iv0 = 1;
    @(negedge clk);
    iv0 = 0; bad0 = 0;
  endtask
  task automatic vec1(input logic [31:0] x, input logic [31:0] y, input logic c, input logic bad);
    a = x; b = y; ci = c; bad1 = bad; iv1 = 1;
    @(negedge clk);
    iv1 = 0; bad1 = 0;
  endtask
  task automatic start0;
    st0 = 1; @(negedge clk); st0 = 0;
  endtask
  task automatic start1;
    st1 = 1; @(negedge clk); st1 = 0;
  endtask
  task automatic wait_done0;
    int n = 0;
    while (!done0 && n < 100) begin @(negedge clk); n++; end
    chk("done0_reached", done0, 1);
  endtask

  initial begin
    #1 rst = 1;
    repeat (2) @(negedge clk);
    chk("reset0", {busy0, done0, flag0, pass0, fail0, fexp0, fgot0}, 0);
    chk("reset1", {busy1, done1, flag1, pass1, fail1, fexp1, fgot1}, 0);
    rst = 0;
    // Valid data before START must not be counted
    a = 1; b = 2; iv0 = 1;
    repeat (3) @(negedge clk);
    start0;
    iv0 = 0;
    chk("prestart_pass", pass0, 0);
    chk("run_busy", busy0, 1);
    for (int k = 0; k < 10; k++) vec0(6'(k * 11 + 3), 6'(k * 7 + 60), k[0], 0);
    wait_done0;
    chk("a_pass", pass0, 10);
    chk("a_fail", fail0, 0);
    chk("a_flag", flag0, 0);
    // Third vector corrupted
    start0;
    for (int k = 0; k < 10; k++)
      if (k == 2) vec0(6'd5, 6'd7, 0, 1);
      else vec0(6'(k * 13 + 1), 6'(k * 5 + 2), ~k[0], 0);
    wait_done0;
    chk("b_fail", fail0, 1);
    chk("b_pass", pass0, 9);
    chk("b_flag", flag0, 1);
    chk("b_fexp", fexp0, 12);
    chk("b_fgot", fgot0, 0);
    // Gapped valids, then trailing valids that must be ignored
    start0;
    for (int k = 0; k < 10; k++) begin
      vec0(6'(63 - k * 3), 6'(k * 9), 1, 0);
      repeat (2) @(negedge clk);
    end
    iv0 = 1;
    repeat (3) @(negedge clk);
    iv0 = 0;
    wait_done0;
    chk("c_pass", pass0, 10);
    chk("c_fail", fail0, 0);
    // Mid-run reset after 4 vectors
    start0;
    for (int k = 0; k < 4; k++) vec0(6'(k + 40), 6'(k + 20), 0, 0);
    chk("d_pass_before_rst", pass0, 3);
    #2 rst = 1;
    #1;
    chk("d_async_clear", {busy0, done0, flag0, pass0, fail0, fexp0, fgot0}, 0);
    rst = 0;
    @(negedge clk);
    chk("d_idle", {busy0, done0}, 0);
    start0;
    for (int k = 0; k < 10; k++) vec0(6'(k * 17), 6'(k * 23), k[1], 0);
    wait_done0;
    chk("e_pass", pass0, 10);
    chk("e_fail", fail0, 0);
    // Combinational adder, 6 vectors, 2-bit counters
    start1;
    vec1(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    chk("l0_first_pass", pass1, 1);
    for (int k = 0; k < 5; k++) vec1(32'(k * 1000), 32'(k * 77), k[0], 0);
    chk("l0_done", {busy1, done1}, 2'b01);
    chk("l0_pass_sat", pass1, 3);
    chk("l0_fail", {flag1, fail1}, 0);
    start1;
    chk("l0_restart", {busy1, done1, pass1}, {1'b1, 1'b0, 2'd0});
    vec1(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1);
    chk("l0_fail_cnt", fail1, 1);
    chk("l0_flag", flag1, 1);
    chk("l0_fexp", fexp1, 33'h1_FFFF_FFFF);
    chk("l0_fgot", fgot1, 0);
    for (int k = 0; k < 5; k++) vec1(32'(k + 5), 32'(k * 3), 0, 0);
    chk("l0_done2", done1, 1);
    chk("l0_pass2", pass1, 3);
    chk("l0_fail2", fail1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
